// File: rtl/uart_pkg.sv
// uart_pkg: shared UART address map, receive FSM states and status bit positions
package uart_pkg;
    localparam logic [31:0] UART_TX_DATA = 32'h0000_1600;
    localparam logic [31:0] UART_TX_STAT = 32'h0000_1604;
    localparam logic [31:0] UART_RX_DATA = 32'h0000_1608;
    localparam logic [31:0] UART_RX_STAT = 32'h0000_160C;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head, extra-MSB pointers
//   clk, rst_n   : clock, async active-low reset
//   push, wdata  : write strobe and data; accepted when not full or popping
//   pop          : read strobe; ignored when empty
//   head         : oldest entry (undefined when empty)
//   full, empty  : occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp, rp;
    logic             do_push, do_pop;

    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    // a pop frees the slot this same edge, so a full FIFO can still take a push
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end

    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 8N1 UART receiver with FIFO, exposed as two load-only registers
//   clk, rst_n  : clock, async active-low reset
//   rx_serial   : asynchronous serial line, idles high
//   addr, mem_rd: core load address and load strobe
//   rd_data     : combinational read data for addr (DATA / STATUS / 0)
//   rd_hit      : addr is one of the receiver registers
//   rx_irq      : registered FIFO non-empty
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_serial,
    input  logic [31:0] addr,
    input  logic        mem_rd,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic        rx_irq
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n, head;
    logic          rx_s1, rx_s2, rx_prev;
    logic          push, ferr_set, overrun, frame_err, full, empty;
    logic          data_sel, stat_sel, pop, stat_rd;
    logic [3:0]    status;

    assign data_sel = addr == UART_RX_DATA;
    assign stat_sel = addr == UART_RX_STAT;
    assign rd_hit   = data_sel || stat_sel;
    assign pop      = mem_rd && data_sel;
    assign stat_rd  = mem_rd && stat_sel;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_serial;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
        end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        shift_n  = shift;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_s2) state_n = START;
            end
            START: if (cnt == HALF_LAST) begin
                cnt_n   = '0;
                state_n = rx_s2 ? IDLE : DATA;
            end
            DATA: if (cnt == BIT_LAST) begin
                cnt_n        = '0;
                shift_n[idx] = rx_s2;
                idx_n        = idx + 1'b1;
                if (idx == 3'd7) state_n = STOP;
            end
            STOP: if (cnt == BIT_LAST) begin
                cnt_n    = '0;
                push     = rx_s2;
                ferr_set = !rx_s2;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (shift),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // set terms come first so a new error survives a same-cycle status read
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_irq    <= 1'b0;
        end else begin
            overrun   <= (push && full && !pop) || (overrun && !stat_rd);
            frame_err <= ferr_set || (frame_err && !stat_rd);
            rx_irq    <= !empty;
        end

    always_comb begin
        status               = '0;
        status[ST_NOT_EMPTY] = !empty;
        status[ST_FULL]      = full;
        status[ST_OVERRUN]   = overrun;
        status[ST_FRAME_ERR] = frame_err;
    end

    assign rd_data = data_sel ? {24'b0, empty ? 8'h00 : head} :
                     stat_sel ? {28'b0, status} : 32'b0;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: randomized self-checking bench against a queue-based receiver model
module tb_uart_rx_mmio;
    localparam int CPB = 16;
    localparam logic [31:0] A_DATA = 32'h0000_1608;
    localparam logic [31:0] A_STAT = 32'h0000_160C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_serial = 1'b1;
    logic [31:0] addr = '0;
    logic        mem_rd = 1'b0;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        rx_irq;

    int n_cmp = 0;
    int n_err = 0;
    int push_lat = 155;

    byte unsigned q[$];
    bit m_ovr, m_ferr;

    uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_serial (rx_serial),
        .addr      (addr),
        .mem_rd    (mem_rd),
        .rd_data   (rd_data),
        .rd_hit    (rd_hit),
        .rx_irq    (rx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_status();
        return {28'b0, m_ferr, m_ovr, q.size() == 8, q.size() != 0};
    endfunction

    function automatic void model_frame(byte unsigned d, logic stop);
        if (!stop) m_ferr = 1'b1;
        else if (q.size() == 8) m_ovr = 1'b1;
        else q.push_back(d);
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [31:0] r;
        r = 32'b0;
        if (a == A_DATA && q.size() != 0) r = {24'b0, q.pop_front()};
        if (a == A_STAT) begin
            r = model_status();
            m_ovr = 1'b0;
            m_ferr = 1'b0;
        end
        return r;
    endfunction

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(logic b);
        @(negedge clk) rx_serial = b;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_frame(byte unsigned d, logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        @(negedge clk) rx_serial = 1'b1;
        idle(3);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic h);
        @(negedge clk);
        addr = a;
        mem_rd = 1'b1;
        #1;
        d = rd_data;
        h = rd_hit;
        @(posedge clk);
        #1;
        mem_rd = 1'b0;
        addr = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic h;
        idle(3);
        n_cmp++;
        if (rx_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", rx_irq); end
        @(negedge clk) rst_n = 1'b1;
        idle(2);
        do_read(A_STAT, d, h);
        n_cmp++;
        if (d !== 32'h0 || h !== 1'b1) begin n_err++; $display("FAIL reset_status got=%h/%b exp=0/1", d, h); end
        do_read(A_DATA, d, h);
        n_cmp++;
        if (d !== 32'h0 || h !== 1'b1) begin n_err++; $display("FAIL reset_data got=%h/%b exp=0/1", d, h); end
        do_read(32'h0000_1600, d, h);
        n_cmp++;
        if (d !== 32'h0 || h !== 1'b0) begin n_err++; $display("FAIL other_addr got=%h/%b exp=0/0", d, h); end
    endtask

    task automatic test_single_frame();
        logic [31:0] d, e;
        logic h;
        int c;
        c = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                @(negedge clk);
                while (rx_irq !== 1'b1 && c < 400) begin
                    @(negedge clk);
                    c++;
                end
            end
        join
        model_frame(8'hA5, 1'b1);
        n_cmp++;
        if (c < 148 || c > 164) begin
            n_err++;
            $display("FAIL single_irq_latency got=%0d exp=148..164", c);
        end else push_lat = c - 1;
        @(negedge clk);
        addr = A_DATA;
        mem_rd = 1'b0;
        idle(2);
        addr = 32'h0;
        do_read(A_STAT, d, h);
        e = model_read(A_STAT);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL single_status got=%h exp=%h", d, e); end
        do_read(A_DATA, d, h);
        e = model_read(A_DATA);
        n_cmp++;
        if (d !== e || d !== 32'hA5) begin n_err++; $display("FAIL single_data got=%h exp=%h", d, e); end
        do_read(A_STAT, d, h);
        e = model_read(A_STAT);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL single_status_after got=%h exp=%h", d, e); end
        idle(1);
        n_cmp++;
        if (rx_irq !== 1'b0) begin n_err++; $display("FAIL single_irq_clear got=%b exp=0", rx_irq); end
    endtask

    task automatic test_burst();
        logic [31:0] d, e;
        logic h;
        for (int b = 1; b <= 9; b++) begin
            send_frame(8'(b), 1'b1);
            model_frame(8'(b), 1'b1);
        end
        for (int r = 0; r < 2; r++) begin
            do_read(A_STAT, d, h);
            e = model_read(A_STAT);
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL burst_status%0d got=%h exp=%h", r, d, e); end
        end
        for (int r = 0; r < 9; r++) begin
            do_read(A_DATA, d, h);
            e = model_read(A_DATA);
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL burst_data%0d got=%h exp=%h", r, d, e); end
        end
        do_read(A_STAT, d, h);
        e = model_read(A_STAT);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL burst_empty_status got=%h exp=%h", d, e); end
    endtask

    task automatic test_frame_err();
        logic [31:0] d, e;
        logic h;
        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0);
        n_cmp++;
        if (rx_irq !== 1'b0) begin n_err++; $display("FAIL ferr_irq got=%b exp=0", rx_irq); end
        do_read(A_STAT, d, h);
        e = model_read(A_STAT);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL ferr_status got=%h exp=%h", d, e); end
        send_frame(8'h7E, 1'b1);
        model_frame(8'h7E, 1'b1);
        do_read(A_DATA, d, h);
        e = model_read(A_DATA);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL ferr_next_data got=%h exp=%h", d, e); end
    endtask

    task automatic test_glitch();
        logic [31:0] d, e;
        logic h;
        @(negedge clk) rx_serial = 1'b0;
        idle(4);
        rx_serial = 1'b1;
        idle(CPB * 12);
        n_cmp++;
        if (rx_irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq got=%b exp=0", rx_irq); end
        do_read(A_STAT, d, h);
        e = model_read(A_STAT);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL glitch_status got=%h exp=%h", d, e); end
    endtask

    task automatic test_race();
        logic [31:0] d, e, rd;
        logic h;
        for (int b = 0; b < 8; b++) begin
            send_frame(8'(8'h40 + b), 1'b1);
            model_frame(8'(8'h40 + b), 1'b1);
        end
        rd = '0;
        fork
            send_frame(8'h48, 1'b1);
            begin
                @(negedge clk);
                repeat (push_lat - 1) @(negedge clk);
                addr = A_DATA;
                mem_rd = 1'b1;
                #1;
                rd = rd_data;
                @(posedge clk);
                #1;
                mem_rd = 1'b0;
                addr = 32'h0;
            end
        join
        e = model_read(A_DATA);
        model_frame(8'h48, 1'b1);
        n_cmp++;
        if (rd !== e) begin n_err++; $display("FAIL race_pop got=%h exp=%h", rd, e); end
        do_read(A_STAT, d, h);
        e = model_read(A_STAT);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL race_status got=%h exp=%h", d, e); end
        for (int r = 0; r < 8; r++) begin
            do_read(A_DATA, d, h);
            e = model_read(A_DATA);
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL race_data%0d got=%h exp=%h", r, d, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, e;
        logic h;
        send_frame(8'h33, 1'b1);
        model_frame(8'h33, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk) rx_serial = 1'b0;
        idle(CPB / 2);
        rst_n = 1'b0;
        rx_serial = 1'b1;
        q.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        addr = A_STAT;
        #1;
        n_cmp++;
        if (rx_irq !== 1'b0 || rd_data !== model_status()) begin
            n_err++;
            $display("FAIL midreset_outputs got=%b/%h exp=0/%h", rx_irq, rd_data, model_status());
        end
        addr = 32'h0;
        idle(3);
        rst_n = 1'b1;
        idle(CPB * 12);
        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1'b1);
        do_read(A_DATA, d, h);
        e = model_read(A_DATA);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL midreset_data got=%h exp=%h", d, e); end
        do_read(A_STAT, d, h);
        e = model_read(A_STAT);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL midreset_status got=%h exp=%h", d, e); end
    endtask

    task automatic test_random();
        logic [31:0] d, e, a;
        logic h;
        byte unsigned b;
        logic stop;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            stop = $urandom_range(0, 3) != 0;
            send_frame(b, stop);
            model_frame(b, stop);
            if ($urandom_range(0, 2) != 0) begin
                a = $urandom_range(0, 1) != 0 ? A_DATA : A_STAT;
                do_read(a, d, h);
                e = model_read(a);
                n_cmp++;
                if (d !== e) begin n_err++; $display("FAIL random%0d addr=%h got=%h exp=%h", i, a, d, e); end
            end
        end
        do_read(A_STAT, d, h);
        e = model_read(A_STAT);
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL random_status got=%h exp=%h", d, e); end
        for (int r = 0; r < 9; r++) begin
            do_read(A_DATA, d, h);
            e = model_read(A_DATA);
            n_cmp++;
            if (d !== e) begin n_err++; $display("FAIL random_drain%0d got=%h exp=%h", r, d, e); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_burst();
        test_frame_err();
        test_glitch();
        test_race();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
